// File: rtl/alu_seq.sv
// Handshaked, registered ALU with a multi-cycle shift-add multiplier.
// Keeps the CPU decoder's 4-bit opcode encoding; results and flags are held until consumed.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int M  = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_CMP = 4'b1000;
   localparam logic [3:0] OP_PASS = 4'b1001;
   localparam logic [3:0] OP_INC = 4'b1010;
   localparam logic [3:0] OP_DEC = 4'b1011;
   localparam logic [3:0] OP_SHL = 4'b1100;
   localparam logic [3:0] OP_SHR = 4'b1101;
   localparam logic [3:0] OP_MUL = 4'b1110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;
   logic               accept;
   logic               is_mul;
   logic               mul_last;
   logic [WIDTH:0]     wide;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;

   assign in_ready  = !reset && (state == IDLE || (state == DONE && out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (opcode == OP_MUL);
   assign mul_last  = (state == BUSY) && (count == CW'(WIDTH - 1));
   // Multiplicand shifts left and multiplier shifts right, so bit 0 is always the current multiplier bit.
   assign prod_next = prod + (mplier[0] ? mcand : '0);

   always_comb begin
      wide    = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (opcode)
         OP_ADD: begin
            wide    = {1'b0, operand_a} + {1'b0, operand_b};
            alu_res = wide[M:0];
            alu_c   = wide[WIDTH];
            alu_v   = (operand_a[M] == operand_b[M]) && (alu_res[M] != operand_a[M]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = operand_a - operand_b;
            alu_c   = operand_a < operand_b;
            alu_v   = (operand_a[M] != operand_b[M]) && (alu_res[M] != operand_a[M]);
         end
         OP_AND:  alu_res = operand_a & operand_b;
         OP_OR:   alu_res = operand_a | operand_b;
         OP_XOR:  alu_res = operand_a ^ operand_b;
         OP_PASS: alu_res = operand_a;
         OP_INC: begin
            wide    = {1'b0, operand_a} + (WIDTH+1)'(1);
            alu_res = wide[M:0];
            alu_c   = wide[WIDTH];
            alu_v   = alu_res[M] & ~operand_a[M];
         end
         OP_DEC: begin
            alu_res = operand_a - WIDTH'(1);
            alu_c   = (operand_a == '0);
            alu_v   = operand_a[M] & ~alu_res[M];
         end
         OP_SHL: begin
            alu_res = operand_a << 1;
            alu_c   = operand_a[M];
         end
         OP_SHR: begin
            alu_res = operand_a >> 1;
            alu_c   = operand_a[0];
         end
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = is_mul ? BUSY : DONE;
         BUSY: if (mul_last) next_state = DONE;
         DONE: if (out_ready) next_state = accept ? (is_mul ? BUSY : DONE) : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         result   <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         negative <= 1'b0;
         overflow <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         prod     <= '0;
         count    <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            if (is_mul) begin
               mcand  <= {{WIDTH{1'b0}}, operand_a};
               mplier <= operand_b;
               prod   <= '0;
               count  <= '0;
            end else begin
               result   <= alu_res;
               zero     <= (alu_res == '0);
               carry    <= alu_c;
               negative <= alu_res[M];
               overflow <= alu_v;
            end
         end else if (state == BUSY) begin
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            // Carry reports any nonzero bit in the discarded high half of the product.
            if (mul_last) begin
               result   <= prod_next[M:0];
               zero     <= (prod_next[M:0] == '0);
               carry    <= |prod_next[2*WIDTH-1:WIDTH];
               negative <= prod_next[M];
               overflow <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes reference results, a monitor checks every transfer.
// The reference model works on plain integers, independent of the RTL structure.
module tb_alu_seq;

   localparam int WIDTH = 8;

   localparam logic [3:0] OP_NONE = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_CMP  = 4'b1000;
   localparam logic [3:0] OP_INC  = 4'b1010;
   localparam logic [3:0] OP_DEC  = 4'b1011;
   localparam logic [3:0] OP_SHL  = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1110;

   typedef struct {
      longint res;
      bit     z;
      bit     c;
      bit     n;
      bit     v;
      longint exp_cycle;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             negative;
   logic             overflow;

   logic        in_valid16;
   logic        in_ready16;
   logic [3:0]  opcode16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        out_valid16;
   logic        out_ready16;
   logic [15:0] result16;
   logic        zero16;
   logic        carry16;
   logic        negative16;
   logic        overflow16;

   exp_t   sb[$];
   int     vectors = 0;
   int     miscompares = 0;
   longint cyc = 0;
   bit     rand_mode = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .carry(carry), .negative(negative), .overflow(overflow)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
      .opcode(opcode16), .operand_a(a16), .operand_b(b16),
      .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
      .zero(zero16), .carry(carry16), .negative(negative16), .overflow(overflow16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 50000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t model(input int w, input logic [3:0] op, input longint a, input longint b);
      exp_t   e;
      longint m;
      longint half;
      longint sa;
      longint sb_;
      longint full;
      longint sres;
      bit     chk;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      sa   = (a >= half) ? a - (m + 1) : a;
      sb_  = (b >= half) ? b - (m + 1) : b;
      e    = '{default: 0};
      full = 0;
      sres = 0;
      chk  = 0;
      case (op)
         4'b0011: begin full = a + b; sres = sa + sb_; chk = 1; e.c = (full > m); end
         4'b0100, 4'b1000: begin full = a - b; sres = sa - sb_; chk = 1; e.c = (a < b); end
         4'b0101: full = a & b;
         4'b0110: full = a | b;
         4'b0111: full = a ^ b;
         4'b1001: full = a;
         4'b1010: begin full = a + 1; sres = sa + 1; chk = 1; e.c = (full > m); end
         4'b1011: begin full = a - 1; sres = sa - 1; chk = 1; e.c = (a == 0); end
         4'b1100: begin full = a * 2; e.c = (a >= half); end
         4'b1101: begin full = a / 2; e.c = (a % 2 == 1); end
         4'b1110: begin full = a * b; e.c = (full > m); end
         default: full = 0;
      endcase
      e.res = full & m;
      e.z   = (e.res == 0);
      e.n   = (e.res >= half);
      e.v   = chk && (sres < -half || sres > half - 1);
      return e;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [WIDTH-1:0] ra();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(WIDTH-1){1'b0}}};
         3: return {1'b0, {(WIDTH-1){1'b1}}};
         default: return WIDTH'($urandom);
      endcase
   endfunction

   task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bit   acc;
      exp_t e;
      acc       = 0;
      in_valid  = 1'b1;
      opcode    = op;
      operand_a = a;
      operand_b = b;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            e = model(WIDTH, op, longint'(a), longint'(b));
            e.exp_cycle = cyc + 1 + ((op == OP_MUL) ? longint'(WIDTH) : 0);
            sb.push_back(e);
         end
         tick();
      end
      in_valid  = 1'b0;
      opcode    = 4'($urandom);
      operand_a = WIDTH'($urandom);
      operand_b = WIDTH'($urandom);
      if (!acc) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 expected accept within 100 cycles");
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && sb.size() != 0; t++) tick();
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   // Monitor: latency at first presentation, stability under backpressure, payload at each transfer.
   bit               prev_valid = 0;
   bit               prev_xfer = 0;
   logic [WIDTH-1:0] prev_res;
   logic [3:0]       prev_flags;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_valid = 0;
         prev_xfer  = 0;
      end else begin
         if (out_valid) begin
            if (!prev_valid || prev_xfer) begin
               if (sb.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_output: got out_valid=1 result=0x%0h expected no pending result", result);
               end else begin
                  checkOutput("latency", cyc, sb[0].exp_cycle);
               end
            end else begin
               checkOutput("bp_result", longint'(result), longint'(prev_res));
               checkOutput("bp_flags", longint'({zero, carry, negative, overflow}), longint'(prev_flags));
            end
            if (!out_ready) checkOutput("bp_in_ready", longint'(in_ready), 0);
            if (out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               checkOutput("result", longint'(result), e.res);
               checkOutput("zero", longint'(zero), longint'(e.z));
               checkOutput("carry", longint'(carry), longint'(e.c));
               checkOutput("negative", longint'(negative), longint'(e.n));
               checkOutput("overflow", longint'(overflow), longint'(e.v));
            end
         end else if (prev_valid && !prev_xfer) begin
            checkOutput("valid_dropped", 0, 1);
         end
         prev_valid = out_valid;
         prev_xfer  = out_valid && out_ready;
         prev_res   = result;
         prev_flags = {zero, carry, negative, overflow};
      end
   end

   initial begin
      exp_t   e16;
      longint t0;
      reset = 1'b1; in_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0; out_ready = 1'b1;
      in_valid16 = 1'b0; opcode16 = '0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checkOutput("rst_out_valid", longint'(out_valid), 0);
      checkOutput("rst_result", longint'(result), 0);
      checkOutput("rst_flags", longint'({zero, carry, negative, overflow}), 0);
      checkOutput("rst_in_ready", longint'(in_ready), 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", longint'(in_ready), 1);
      tick();

      $display("[TB] directed arithmetic");
      applyStimulus(OP_ADD, 8'hFF, 8'h01);
      applyStimulus(OP_SUB, 8'h80, 8'h01);
      applyStimulus(OP_CMP, 8'h01, 8'h02);
      drain();

      $display("[TB] multiply latency");
      applyStimulus(OP_MUL, 8'h0F, 8'h11);
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         checkOutput("busy_in_ready", longint'(in_ready), 0);
         checkOutput("busy_out_valid", longint'(out_valid), 0);
         tick();
      end
      drain();
      applyStimulus(OP_MUL, 8'h10, 8'h10);
      drain();

      $display("[TB] backpressure then streaming");
      out_ready = 1'b0;
      applyStimulus(OP_ADD, 8'h7F, 8'h01);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bp_out_valid", longint'(out_valid), 1);
         tick();
      end
      out_ready = 1'b1;
      t0 = cyc;
      applyStimulus(OP_SUB, 8'h10, 8'h20);
      applyStimulus(OP_INC, 8'h7F, 8'h00);
      applyStimulus(OP_DEC, 8'h00, 8'h00);
      applyStimulus(OP_SHR, 8'h01, 8'h00);
      checkOutput("stream_cycles", cyc - t0, 4);
      drain();

      $display("[TB] reset during multiply");
      applyStimulus(OP_MUL, 8'hA5, 8'h3C);
      tick();
      tick();
      tick();
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_busy_in_ready", longint'(in_ready), 0);
      sb.delete();
      tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_out_valid", longint'(out_valid), 0);
      checkOutput("abort_result", longint'(result), 0);
      checkOutput("abort_flags", longint'({zero, carry, negative, overflow}), 0);
      checkOutput("abort_in_ready", longint'(in_ready), 1);
      repeat (12) tick();

      $display("[TB] edge opcodes");
      applyStimulus(OP_NONE, 8'h55, 8'h00);
      applyStimulus(OP_SHL, 8'h81, 8'h00);
      drain();

      $display("[TB] 16-bit instance");
      in_valid16 = 1'b1; opcode16 = OP_ADD; a16 = 16'hFFFF; b16 = 16'h0001;
      @(negedge clk);
      checkOutput("w16_in_ready", longint'(in_ready16), 1);
      e16 = model(16, OP_ADD, 64'hFFFF, 64'h1);
      tick();
      in_valid16 = 1'b0;
      a16 = 16'h1234;
      @(negedge clk);
      checkOutput("w16_out_valid", longint'(out_valid16), 1);
      checkOutput("w16_result", longint'(result16), e16.res);
      checkOutput("w16_carry", longint'(carry16), longint'(e16.c));
      checkOutput("w16_zero", longint'(zero16), longint'(e16.z));
      tick();

      $display("[TB] random traffic");
      rand_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) tick();
         applyStimulus(4'($urandom), ra(), ra());
      end
      rand_mode = 0;
      out_ready = 1'b1;
      drain();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
